// File: rtl/fp_fmt_pkg.sv
// Shared FP word-format definitions: field widths, packer FSM states and canonical special encodings.
// The helpers return the top 10 bits {sign, exp, mant msb}; callers zero-fill the remaining mantissa bits.
package fp_fmt_pkg;
  localparam int         EXP_W    = 8;
  localparam logic [7:0] EXP_MAX  = 8'hFF;
  localparam int         EXP_IN_W = 10;

  typedef enum logic [1:0] {IDLE, NORM, DONE} pack_state_e;

  function automatic logic [9:0] canon_nan();
    return {1'b0, EXP_MAX, 1'b1};
  endfunction

  function automatic logic [9:0] inf(input logic sign);
    return {sign, EXP_MAX, 1'b0};
  endfunction

  function automatic logic [9:0] zero(input logic sign);
    return {sign, 8'h00, 1'b0};
  endfunction
endpackage

// File: rtl/fp_result_packer_if.sv
// Result-packer handshake bundle: unpacked FP result in, packed word plus class flags out.
interface fp_result_packer_if #(parameter int DATA_W = 64);
  localparam int MANT_W = DATA_W - 9;

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [9:0]        in_exp;
  logic [MANT_W:0]   in_mant;
  logic              in_nan;
  logic              in_inf;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_digit;
  logic              out_nan;
  logic              out_inf;
  logic              out_zero;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, out_ready,
    input  in_ready, out_valid, out_digit, out_nan, out_inf, out_zero
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, out_ready,
    output in_ready, out_valid, out_digit, out_nan, out_inf, out_zero
  );
endinterface

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports W.
module fp_lzc #(
  parameter int W  = 24,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  d,
  output logic [CW-1:0] cnt
);
  logic found;

  always_comb begin
    cnt   = CW'(W);
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && d[i]) begin
        cnt   = CW'(W - 1 - i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fp_result_packer.sv
// Normalizes an FP result and packs it into sign|exp8|mant, saturating to INF or flushing to zero.
// FP_PACK_FAST_NORM_EN selects a single-cycle lzc-based normalize instead of the 1-bit/cycle loop.
module fp_result_packer
  import fp_fmt_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input logic             clk,
  input logic             rst_n,
  fp_result_packer_if.slave bus
);
  localparam int MANT_W = DATA_W - 9;

  pack_state_e        state, state_d;
  logic               sign_q, nan_q, inf_q;
  logic signed [9:0]  exp_q, fin_exp;
  logic [MANT_W:0]    mant_q, fin_mant;
  logic [DATA_W-1:0]  digit_q, digit_d;
  logic [2:0]         flags_q, flags_d;
  logic               ld, step, fin, step_ok;

`ifdef FP_PACK_FAST_NORM_EN
  localparam int LCW = $clog2(MANT_W + 2);
  logic [LCW-1:0]    lzc;
  logic signed [9:0] lz10, exp_m1, sh;

  fp_lzc #(.W(MANT_W + 1), .CW(LCW)) u_lzc (.d(mant_q), .cnt(lzc));

  // Shift stops at the hidden bit or when exp reaches 1, matching the iterative loop exactly.
  always_comb begin
    lz10     = 10'(lzc);
    exp_m1   = exp_q - 10'sd1;
    sh       = (exp_q > 10'sd1) ? ((lz10 < exp_m1) ? lz10 : exp_m1) : 10'sd0;
    fin_mant = mant_q << sh;
    fin_exp  = exp_q - sh;
    step_ok  = 1'b0;
  end
`else
  always_comb begin
    fin_mant = mant_q;
    fin_exp  = exp_q;
    step_ok  = !mant_q[MANT_W] && (exp_q > 10'sd1);
  end
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_d;

  always_comb begin
    state_d = state;
    ld      = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    digit_d = digit_q;
    flags_d = flags_q;
    case (state)
      IDLE: if (bus.in_valid) begin
        state_d = NORM;
        ld      = 1'b1;
      end
      NORM: begin
        fin = 1'b1;
        if (nan_q) begin
          digit_d = {canon_nan(), {(MANT_W-1){1'b0}}};
          flags_d = 3'b100;
        end else if (inf_q) begin
          digit_d = {inf(sign_q), {(MANT_W-1){1'b0}}};
          flags_d = 3'b010;
        end else if (mant_q == '0) begin
          digit_d = {zero(sign_q), {(MANT_W-1){1'b0}}};
          flags_d = 3'b001;
        end else if (step_ok) begin
          fin  = 1'b0;
          step = 1'b1;
        end else if (fin_exp >= 10'sd255) begin
          digit_d = {inf(sign_q), {(MANT_W-1){1'b0}}};
          flags_d = 3'b010;
        end else if (fin_exp <= 10'sd0 || !fin_mant[MANT_W]) begin
          digit_d = {zero(sign_q), {(MANT_W-1){1'b0}}};
          flags_d = 3'b001;
        end else begin
          digit_d = {sign_q, fin_exp[7:0], fin_mant[MANT_W-1:0]};
          flags_d = 3'b000;
        end
        if (fin) state_d = DONE;
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q  <= 1'b0;
      nan_q   <= 1'b0;
      inf_q   <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      digit_q <= '0;
      flags_q <= '0;
    end else begin
      if (ld) begin
        sign_q <= bus.in_sign;
        nan_q  <= bus.in_nan;
        inf_q  <= bus.in_inf;
        exp_q  <= bus.in_exp;
        mant_q <= bus.in_mant;
      end else if (step) begin
        mant_q <= mant_q << 1;
        exp_q  <= exp_q - 10'sd1;
      end
      if (fin) begin
        digit_q <= digit_d;
        flags_q <= flags_d;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_digit = digit_q;
  assign bus.out_nan   = flags_q[2];
  assign bus.out_inf   = flags_q[1];
  assign bus.out_zero  = flags_q[0];
endmodule

// File: tb/tb_fp_result_packer.sv
// Directed plus randomized bench for fp_result_packer at DATA_W=32 against an arithmetic reference model.
module tb_fp_result_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp_result_packer_if #(.DATA_W(32)) bus ();
  fp_result_packer #(.DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: normalize by counting leading zeros, clamp the shift so exp never drops below 1.
  function automatic logic [34:0] model(input logic s, input logic signed [9:0] e10,
                                        input logic [23:0] m, input logic nan, input logic inf,
                                        output int sh);
    int e, lz, e2;
    logic [23:0] m2;
    e  = e10;
    sh = 0;
    if (nan) return {3'b100, 32'h7FC00000};
    if (inf) return {3'b010, s, 8'hFF, 23'd0};
    if (m == 0) return {3'b001, s, 31'd0};
    lz = 0;
    while (!m[23 - lz]) lz++;
    if (e > 1) sh = (lz < e - 1) ? lz : e - 1;
    m2 = m << sh;
    e2 = e - sh;
    if (e2 >= 255) return {3'b010, s, 8'hFF, 23'd0};
    if (e2 <= 0 || !m2[23]) return {3'b001, s, 31'd0};
    return {3'b000, s, e2[7:0], m2[22:0]};
  endfunction

  task automatic drive(input logic s, input logic [9:0] e, input logic [23:0] m,
                       input logic nan, input logic inf);
    int n = 0;
    while (!bus.in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) chk("ready_timeout", 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_sign = s; bus.in_exp = e; bus.in_mant = m;
    bus.in_nan = nan; bus.in_inf = inf;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (lat >= 100) chk("valid_timeout", 0, 1);
  endtask

  task automatic run(input string tag, input logic s, input logic [9:0] e, input logic [23:0] m,
                     input logic nan, input logic inf, input bit chk_lat);
    logic [34:0] exp_v;
    int sh, lat;
    exp_v = model(s, e, m, nan, inf, sh);
    drive(s, e, m, nan, inf);
    wait_out(lat);
    chk({tag, "_digit"}, bus.out_digit, exp_v[31:0]);
    chk({tag, "_flags"}, {bus.out_nan, bus.out_inf, bus.out_zero}, exp_v[34:32]);
`ifdef FP_PACK_FAST_NORM_EN
    if (chk_lat) chk({tag, "_lat"}, lat, 1);
`else
    if (chk_lat) chk({tag, "_lat"}, lat, 1 + sh);
`endif
    @(posedge clk); #1;
    chk({tag, "_ret"}, {bus.out_valid, bus.in_ready}, 2'b01);
  endtask

  initial begin
    logic [31:0] held;
    int lat;
    bus.in_valid = 0; bus.in_sign = 0; bus.in_exp = 0; bus.in_mant = 0;
    bus.in_nan = 0; bus.in_inf = 0; bus.out_ready = 1;
    #12;
    chk("rst_state", {bus.out_valid, bus.in_ready, bus.out_digit,
                      bus.out_nan, bus.out_inf, bus.out_zero}, {2'b01, 32'd0, 3'b000});
    @(negedge clk); rst_n = 1'b1;

    run("c1", 0, 10'd127, 24'h800000, 0, 0, 1);
    run("c2", 0, 10'd130, 24'h200000, 0, 0, 1);
    run("c3inf", 1, 10'd300, 24'h800000, 0, 0, 1);
    run("c3nan", 1, 10'd127, 24'h800000, 1, 0, 1);
    run("c4flush", 1, 10'd1, 24'h400000, 0, 0, 1);
    run("c4zero", 0, 10'd127, 24'h000000, 0, 0, 1);
    run("negexp", 0, 10'h3F0, 24'h800000, 0, 0, 1);
    run("exp254", 1, 10'd254, 24'hC00001, 0, 0, 1);

    // Backpressure: result must hold while further beats are offered.
    bus.out_ready = 0;
    drive(0, 10'd127, 24'h800000, 0, 0);
    wait_out(lat);
    held = bus.out_digit;
    chk("bp_first", held, 32'h3F800000);
    @(negedge clk);
    bus.in_valid = 1; bus.in_exp = 10'd200; bus.in_mant = 24'hABCDEF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {bus.out_valid, bus.in_ready, bus.out_digit}, {2'b10, held});
    end
    @(negedge clk); bus.out_ready = 1;
    @(posedge clk); #1;
    chk("bp_release", {bus.out_valid, bus.in_ready}, 2'b01);
    bus.in_valid = 0;
    @(posedge clk); #1;

    // Async reset mid-normalize discards the beat.
    drive(0, 10'd130, 24'h200000, 0, 0);
    #1 rst_n = 0;
    #1 chk("rst_mid", {bus.out_valid, bus.in_ready, bus.out_digit}, {2'b01, 32'd0});
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_nostale", {bus.out_valid, bus.in_ready}, 2'b01);
    end
    run("rst_next", 0, 10'd127, 24'h800000, 0, 0, 1);

    for (int i = 0; i < 200; i++) begin
      logic [9:0] e;
      logic [23:0] m;
      logic s, nan, inf;
      case ($urandom_range(0, 3))
        0: e = 10'($urandom);
        1: e = 10'($urandom_range(0, 40));
        2: e = 10'($urandom_range(240, 270));
        default: e = 10'($urandom_range(100, 150));
      endcase
      m   = 24'($urandom) >> $urandom_range(0, 24);
      s   = 1'($urandom);
      nan = ($urandom_range(0, 15) == 0);
      inf = ($urandom_range(0, 15) == 0);
      run("rand", s, e, m, nan, inf, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
